pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage core (IF, ID, EX, MEM, WB). It merges bus-wait requests from IF/MEM, detects load-use hazards on the ID operand reads, and sequences multi-cycle mult/div in EX with an internal FSM/counter. It produces one per-stage stall vector and a flush pulse with redirect PC, consumed by every pipeline register and the PC unit.

Parameters:
MULT_CYCLES, 2, EX cycles a multiply occupies after issue (>=1)
DIV_CYCLES, 16, EX cycles a divide occupies after issue (>=1)
CNT_W, 5, width of the mult/div down-counter (must hold DIV_CYCLES-1)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
id_read_en_1  in  1  ID reads register port 1
id_read_addr_1  in  5  ID register address, port 1
id_read_en_2  in  1  ID reads register port 2
id_read_addr_2  in  5  ID register address, port 2
ex_load  in  1  instruction in EX is a load (LB/LBU/LW)
ex_write_addr  in  5  destination register of the EX instruction
ex_md_start  in  1  instruction in EX is mult/div, held while it sits in EX
ex_md_is_div  in  1  qualifies ex_md_start: 1 = divide, 0 = multiply
if_bus_busy  in  1  instruction fetch not yet returned
mem_bus_busy  in  1  data access in MEM not yet complete
flush_req  in  1  taken exception/redirect from MEM
flush_target  in  32  redirect PC accompanying flush_req
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
flush  out  1  clear IF/ID/EX/MEM pipeline registers this cycle
flush_pc  out  32  PC to load when flush=1
ex_md_done  out  1  mult/div result valid in EX this cycle
stall_count  out  32  cycles with stall[0]=1 since reset, saturating

Behaviour:
- Reset (rst=0 at edge): md FSM to IDLE, counter 0, flush_pending 0, stall_count 0. Combinational outputs stall, flush, flush_pc, ex_md_done are forced to 0 while rst=0.
- Load-use hazard: ex_load & ex_write_addr!=0 & ((id_read_en_1 & id_read_addr_1==ex_write_addr) | (id_read_en_2 & id_read_addr_2==ex_write_addr)). A read of $0 never hazards.
- md FSM states IDLE, BUSY, DONE; counter CNT_W bits.
  - IDLE: ex_md_start=1 -> counter <= (is_div ? DIV_CYCLES : MULT_CYCLES)-1, go BUSY; EX stall asserted this cycle.
  - BUSY: EX stall asserted; counter==0 -> DONE, else counter decrements. Counting continues regardless of mem_bus_busy.
  - DONE: ex_md_done=1, no EX stall; if mem_bus_busy=1 stay DONE (ex_md_done held), else go IDLE. ex_md_start is ignored in DONE.
  - Net: issue at cycle t -> EX stall t..t+N, ex_md_done at t+N+1 (N = MULT_CYCLES or DIV_CYCLES).
  - Flush (flush=1) in any state -> IDLE next cycle.
- Stall priority (highest first; the lower bits are always set with a higher request):
  - mem_bus_busy -> 011111
  - md EX stall -> 001111
  - load-use -> 000111
  - if_bus_busy -> 000011
  - none -> 000000
- Flush:
  - flush_req & !mem_bus_busy & !flush_pending -> flush=1, flush_pc=flush_target same cycle.
  - flush_req while mem_bus_busy -> flush_pending<=1, target latched; no flush yet, stall=011111.
  - first cycle with mem_bus_busy=0 and flush_pending=1 -> flush=1, flush_pc=latched target, pending cleared. A flush_req in that same cycle is ignored; the pending flush wins.
  - flush=1 forces stall=000000 that cycle.
  - flush is one cycle per request.
- stall_count increments when stall[0]=1; saturates at 0xFFFFFFFF.

Test Plan:
- Reset: hold rst=0 2 cycles with all requests high -> stall=0, flush=0, ex_md_done=0, stall_count=0; after release FSM IDLE.
- Load-use: ex_load=1, ex_write_addr=8, id_read_en_2=1, id_read_addr_2=8 -> stall=000111; same with addr 0 -> stall=000000.
- Multiply, MULT_CYCLES=2: ex_md_start=1, is_div=0 at cycle 0 -> stall=001111 cycles 0..2, ex_md_done=1 cycle 3, stall_count=3.
- Divide overlapped with MEM wait, DIV_CYCLES=16: issue at 0, mem_bus_busy=1 cycles 15..18 -> stall=011111 cycles 15..18, ex_md_done high cycles 17..19, IDLE at 20.
- Deferred flush: flush_req=1, flush_target=0xBFC00380 with mem_bus_busy=1 for 3 cycles -> no flush, stall=011111; first free cycle flush=1, flush_pc=0xBFC00380, stall=0, single pulse.
- Flush aborts divide: issue divide, flush_req at cycle 5 with bus idle -> flush=1 cycle 5, FSM IDLE cycle 6, no ex_md_done.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage core: merges bus waits, load-use
// hazards and multi-cycle mult/div into one per-stage stall vector plus a flush pulse.
module pipeline_ctrl #(
    parameter int MULT_CYCLES = 2,
    parameter int DIV_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_read_en_1,
    input  logic [4:0]  id_read_addr_1,
    input  logic        id_read_en_2,
    input  logic [4:0]  id_read_addr_2,
    input  logic        ex_load,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        if_bus_busy,
    input  logic        mem_bus_busy,
    input  logic        flush_req,
    input  logic [31:0] flush_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        ex_md_done,
    output logic [31:0] stall_count,
    output logic [1:0]  md_state
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [31:0]      sc_q, sc_d;

    logic hazard;
    logic md_stall;
    logic md_done;
    logic fire_pend;
    logic fire_new;
    logic flush_int;

    always_comb begin
        hazard = ex_load && (ex_write_addr != 5'd0) &&
                 ((id_read_en_1 && (id_read_addr_1 == ex_write_addr)) ||
                  (id_read_en_2 && (id_read_addr_2 == ex_write_addr)));
    end

    // A pending (deferred) flush always beats a new request in the same cycle.
    always_comb begin
        fire_pend = pend_q && !mem_bus_busy;
        fire_new  = flush_req && !mem_bus_busy && !pend_q;
        flush_int = rst && (fire_pend || fire_new);
        pend_d    = pend_q;
        tgt_d     = tgt_q;
        if (fire_pend || fire_new) begin
            pend_d = 1'b0;
        end else if (flush_req && mem_bus_busy && !pend_q) begin
            pend_d = 1'b1;
            tgt_d  = flush_target;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (ex_md_start) begin
                    md_stall = 1'b1;
                    cnt_d    = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MD_DONE: begin
                md_done = 1'b1;
                if (!mem_bus_busy) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_int) begin
            state_d = MD_IDLE;
        end
    end

    always_comb begin
        stall = 6'b000000;
        if (rst && !flush_int) begin
            if (mem_bus_busy)     stall = 6'b011111;
            else if (md_stall)    stall = 6'b001111;
            else if (hazard)      stall = 6'b000111;
            else if (if_bus_busy) stall = 6'b000011;
            else                  stall = 6'b000000;
        end
        flush      = flush_int;
        flush_pc   = flush_int ? (fire_pend ? tgt_q : flush_target) : 32'd0;
        ex_md_done = rst && md_done;
        sc_d       = sc_q;
        if (stall[0] && (sc_q != 32'hFFFF_FFFF)) begin
            sc_d = sc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tgt_q   <= 32'd0;
            sc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            sc_q    <= sc_d;
        end
    end

    assign stall_count = sc_q;
    assign md_state    = state_q;

endmodule
